// File: rtl/infoframe_packet_buffer.sv
// InfoFrame payload buffer: shadow bytes are checksummed on commit and published atomically on frame_sync.
// Optional shadow readback port (rd_addr/rd_data) is built only when INFOFRAME_READBACK_EN is defined.
module infoframe_packet_buffer #(
    parameter logic [6:0]      TYPE            = 7'd3,
    parameter logic [7:0]      VERSION         = 8'd1,
    parameter logic [4:0]      LENGTH          = 5'd25,
    parameter logic [8*27-1:0] DEFAULT_PAYLOAD = 216'd0
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             commit,
    input  logic             frame_sync,
`ifdef INFOFRAME_READBACK_EN
    input  logic [4:0]       rd_addr,
    output logic [7:0]       rd_data,
`endif
    output logic             busy,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CHECKSUM = 2'd1;
    localparam logic [1:0] ST_PENDING  = 2'd2;

    localparam logic [23:0] HEADER  = {3'b000, LENGTH, VERSION, 1'b1, TYPE};
    localparam logic [7:0]  HDR_SUM = HEADER[7:0] + HEADER[15:8] + HEADER[23:16];

    // Bytes beyond LENGTH are reserved and must always read as zero.
    function automatic logic [215:0] mask_payload(input logic [215:0] p);
        logic [215:0] m;
        m = p;
        for (int i = 0; i < 27; i++) begin
            m[8*i +: 8] = (i >= int'(LENGTH)) ? 8'h00 : p[8*i +: 8];
        end
        return m;
    endfunction

    function automatic logic [7:0] calc_checksum(input logic [7:0] hdr_sum, input logic [215:0] p);
        logic [7:0] s;
        s = hdr_sum;
        for (int i = 0; i < 27; i++) begin
            s = s + p[8*i +: 8];
        end
        return 8'h00 - s;
    endfunction

    localparam logic [215:0] PAYLOAD_RST  = mask_payload(DEFAULT_PAYLOAD);
    localparam logic [7:0]   CHECKSUM_RST = calc_checksum(HDR_SUM, PAYLOAD_RST);

    logic [1:0] state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] acc_q, acc_d;
    logic       busy_q;
    logic [7:0] shadow_q [1:27];
    logic [7:0] active_q [0:27];
    logic       wr_accept_s;
    logic       swap_s;
    logic [7:0] shadow_rd_s;

    assign wr_accept_s = wr_en && (state_q == ST_IDLE) &&
                         (wr_addr >= 5'd1) && (wr_addr <= LENGTH);

    // Next-state logic: accumulate one shadow byte per cycle, then wait for frame_sync.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        swap_s      = 1'b0;
        shadow_rd_s = shadow_q[idx_q];
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d = ST_CHECKSUM;
                    idx_d   = 5'd1;
                    acc_d   = HDR_SUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECKSUM: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == LENGTH) begin
                    state_d = ST_PENDING;
                    acc_d   = 8'h00 - (acc_q + shadow_rd_s);
                end else begin
                    acc_d   = acc_q + shadow_rd_s;
                end
            end
            ST_PENDING: begin
                if (frame_sync) begin
                    state_d = ST_IDLE;
                    swap_s  = 1'b1;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; busy is registered from the next state so it tracks state_q exactly.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            acc_q   <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Shadow payload, written only through the accepted write port.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= 27; i++) begin
                shadow_q[i] <= PAYLOAD_RST[8*(i-1) +: 8];
            end
        end else if (wr_accept_s) begin
            shadow_q[wr_addr] <= wr_data;
        end
    end

    // Active payload plus checksum, replaced in a single edge at the swap.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            active_q[0] <= CHECKSUM_RST;
            for (int i = 1; i <= 27; i++) begin
                active_q[i] <= PAYLOAD_RST[8*(i-1) +: 8];
            end
        end else if (swap_s) begin
            active_q[0] <= acc_q;
            for (int i = 1; i <= 27; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Pack active bytes into the four 7-byte subpackets (pure wiring of registers).
    always_comb begin
        sub = {4{56'd0}};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                sub[i][8*j +: 8] = active_q[7*i + j];
            end
        end
    end

    assign header = HEADER;
    assign busy   = busy_q;

`ifdef INFOFRAME_READBACK_EN
    logic [7:0] rd_data_q;

    // Registered shadow readback; index 0 and reserved indices return zero.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else if ((rd_addr >= 5'd1) && (rd_addr <= LENGTH)) begin
            rd_data_q <= shadow_q[rd_addr];
        end else begin
            rd_data_q <= 8'h00;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_infoframe_packet_buffer.sv
// Bench for infoframe_packet_buffer: directed vector table, reset corner cases, and random traffic vs. a reference model.
`timescale 1ns/1ps
module tb_infoframe_packet_buffer;

    logic             clk_pixel = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic [4:0]       wr_addr = 5'd0;
    logic [7:0]       wr_data = 8'h00;
    logic             commit = 1'b0;
    logic             frame_sync = 1'b0;
    logic             busy;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
`ifdef INFOFRAME_READBACK_EN
    logic [4:0]       rd_addr = 5'd0;
    logic [7:0]       rd_data;
`endif

    localparam int LEN = 25;
    localparam logic [23:0] HDR_EXP = 24'h190183;

    int pass_cnt  = 0;
    int total_cnt = 0;

    infoframe_packet_buffer dut (
        .clk_pixel  (clk_pixel),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .frame_sync (frame_sync),
`ifdef INFOFRAME_READBACK_EN
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
`endif
        .busy       (busy),
        .header     (header),
        .sub        (sub)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Reference model: payload bytes as plain integers, publish after LENGTH+1 cycles since commit.
    int sh [1:27];
    int act [0:27];
    bit busy_m;
    int since_commit;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic int hdr_sum();
        return int'(HDR_EXP[7:0]) + int'(HDR_EXP[15:8]) + int'(HDR_EXP[23:16]);
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 27; i++) sh[i] = 0;
        for (int i = 0; i <= 27; i++) act[i] = 0;
        act[0] = (256 - (hdr_sum() % 256)) % 256;
        busy_m = 1'b0;
        since_commit = 0;
    endtask

    task automatic model_edge(input bit we, input int a, input int d, input bit cm, input bit fs);
        int s;
        if (!busy_m) begin
            if (we && a >= 1 && a <= LEN) sh[a] = d;
            if (cm) begin
                busy_m = 1'b1;
                since_commit = 0;
            end
        end else begin
            since_commit++;
            if (fs && since_commit > LEN) begin
                s = hdr_sum();
                for (int i = 1; i <= 27; i++) begin
                    s += sh[i];
                    act[i] = sh[i];
                end
                act[0] = (256 - (s % 256)) % 256;
                busy_m = 1'b0;
            end
        end
    endtask

    function automatic logic [55:0] exp_sub(input int i);
        logic [55:0] v;
        v = 56'd0;
        for (int j = 0; j < 7; j++) v[8*j +: 8] = 8'(act[7*i + j]);
        return v;
    endfunction

    task automatic check_invariant(input string tag);
        int s;
        s = int'(header[7:0]) + int'(header[15:8]) + int'(header[23:16]);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 7; j++) s += int'(sub[i][8*j +: 8]);
        check({tag, " invariant"}, 64'(s % 256), 64'd0);
    endtask

    task automatic check_model(input string tag);
        check({tag, " busy"}, 64'(busy), 64'(busy_m));
        check({tag, " header"}, 64'(header), 64'(HDR_EXP));
        for (int i = 0; i < 4; i++)
            check($sformatf("%s sub%0d", tag, i), 64'(sub[i]), 64'(exp_sub(i)));
        check_invariant(tag);
    endtask

    task automatic drive(input bit we, input logic [4:0] a, input logic [7:0] d, input bit cm, input bit fs);
        wr_en = we; wr_addr = a; wr_data = d; commit = cm; frame_sync = fs;
        @(posedge clk_pixel); #1;
        model_edge(we, int'(a), int'(d), cm, fs);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " header"}, 64'(header), 64'h190183);
        check({tag, " sub0"}, 64'(sub[0]), 64'h63);
        check({tag, " sub1"}, 64'(sub[1]), 64'd0);
        check({tag, " sub2"}, 64'(sub[2]), 64'd0);
        check({tag, " sub3"}, 64'(sub[3]), 64'd0);
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [7:0]  data;
        bit          cm;
        bit          fs;
        int          rep;
        bit          exp_busy;
        logic [55:0] exp_sub0;
        logic [55:0] exp_sub3;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // write PB1, commit, frame_sync 40 cycles after commit
        tbl.push_back('{1'b1, 5'd1,  8'h41, 1'b0, 1'b0, 1,  1'b0, 56'h63,       56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1,  1'b1, 56'h63,       56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 39, 1'b1, 56'h63,       56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 1,  1'b0, 56'h4122,     56'h0});
        // activity while busy is ignored; fs at cycle LENGTH is too early, LENGTH+1 swaps
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1,  1'b1, 56'h4122,     56'h0});
        tbl.push_back('{1'b1, 5'd2,  8'h55, 1'b1, 1'b1, 1,  1'b1, 56'h4122,     56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 23, 1'b1, 56'h4122,     56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 1,  1'b1, 56'h4122,     56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 1,  1'b0, 56'h4122,     56'h0});
        // out-of-range writes dropped
        tbl.push_back('{1'b1, 5'd0,  8'hAA, 1'b0, 1'b0, 1,  1'b0, 56'h4122,     56'h0});
        tbl.push_back('{1'b1, 5'd26, 8'hBB, 1'b0, 1'b0, 1,  1'b0, 56'h4122,     56'h0});
        tbl.push_back('{1'b1, 5'd31, 8'hCC, 1'b0, 1'b0, 1,  1'b0, 56'h4122,     56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1,  1'b1, 56'h4122,     56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 25, 1'b1, 56'h4122,     56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 1,  1'b0, 56'h4122,     56'h0});
        // write in the commit cycle is included in the checksum
        tbl.push_back('{1'b1, 5'd3,  8'h10, 1'b1, 1'b0, 1,  1'b1, 56'h4122,     56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 25, 1'b1, 56'h4122,     56'h0});
        tbl.push_back('{1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 1,  1'b0, 56'h10004112, 56'h0});

        model_reset();
        repeat (3) @(posedge clk_pixel);
        #1;
        check_reset_values("in_reset");
        reset = 1'b0;
        @(posedge clk_pixel); #1;
        check_reset_values("after_reset");

        for (int k = 0; k < tbl.size(); k++) begin
            for (int r = 0; r < tbl[k].rep; r++) begin
                drive(tbl[k].we, tbl[k].addr, tbl[k].data, tbl[k].cm, tbl[k].fs);
                check($sformatf("vec%0d busy", k), 64'(busy), 64'(tbl[k].exp_busy));
                check($sformatf("vec%0d sub0", k), 64'(sub[0]), 64'(tbl[k].exp_sub0));
                check($sformatf("vec%0d sub3", k), 64'(sub[3]), 64'(tbl[k].exp_sub3));
            end
        end

        // reset while PENDING abandons the commit
        drive(1'b1, 5'd1, 8'h41, 1'b1, 1'b0);
        repeat (26) drive(1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
        check("pending busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_values("reset_in_pending");
        @(posedge clk_pixel); #1;
        reset = 1'b0;
        model_reset();

        // reset mid-CHECKSUM loses pre-reset shadow writes
        drive(1'b1, 5'd1, 8'h77, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk_pixel); #1;
        reset = 1'b0;
        model_reset();
        drive(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
        repeat (25) drive(1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
        check("reset_in_checksum busy", 64'(busy), 64'd0);
        check("reset_in_checksum sub0", 64'(sub[0]), 64'h63);

`ifdef INFOFRAME_READBACK_EN
        drive(1'b1, 5'd9, 8'h56, 1'b0, 1'b0);
        rd_addr = 5'd9;
        drive(1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
        check("readback pb9", 64'(rd_data), 64'h56);
        check("readback sub1", 64'(sub[1]), 64'd0);
        rd_addr = 5'd0;
        drive(1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
        check("readback addr0", 64'(rd_data), 64'd0);
`endif

        check_model("pre_random");
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), 8'($urandom),
                  $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
